// File: rtl/conv_result_drain.sv
// Collects one convolution result frame into RESULT_D banks, then streams it channel-major over valid/ready.
// Optional CONV_RESULT_DRAIN_RELU_EN: clamp negative result words to zero at the output register stage.
module conv_result_drain #(
  parameter int DATA_WIDTH            = 8,
  parameter int RESULT_W              = 6,
  parameter int RESULT_H              = 6,
  parameter int RESULT_D              = 8,
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W*RESULT_H),
  parameter int CH_ADDR_WIDTH         = (RESULT_D > 1) ? $clog2(RESULT_D) : 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0]   result_wraddress,
  input  logic [DATA_WIDTH*4*RESULT_D-1:0]            result_data_out,
  input  logic [RESULT_D-1:0]                         result_wren,
  output logic [DATA_WIDTH*4-1:0]                     out_data,
  output logic [CH_ADDR_WIDTH-1:0]                    out_ch,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]            out_addr,
  output logic                                        out_last,
  output logic                                        out_val,
  input  logic                                        out_rdy,
  output logic                                        busy,
  output logic                                        err_overrun
);

  localparam int RES_WIDTH = DATA_WIDTH*4;
  localparam int AW        = RESULT_RAM_ADDR_WIDTH;
  localparam int CW        = CH_ADDR_WIDTH;
  localparam int N         = RESULT_W*RESULT_H;
  localparam int CNT_W     = $clog2(N+1);

  typedef enum logic {S_COLLECT, S_DRAIN} state_t;

  typedef struct packed {
    logic [RES_WIDTH-1:0] data;
    logic [CW-1:0]        ch;
    logic [AW-1:0]        addr;
    logic                 last;
  } beat_t;

  function automatic logic [RES_WIDTH-1:0] f_relu(input logic signed [RES_WIDTH-1:0] x);
`ifdef CONV_RESULT_DRAIN_RELU_EN
    f_relu = (x < 0) ? '0 : x;
`else
    f_relu = x;
`endif
  endfunction

  state_t                              r_state;
  logic [CNT_W-1:0]                    r_frame_cnt;
  logic [AW-1:0]                       r_rd_addr;
  logic [CW-1:0]                       r_rd_ch;
  logic                                r_rd_done;
  logic                                r_err;

  logic                                r_vld_p1;
  logic [CW-1:0]                       r_ch_p1;
  logic [AW-1:0]                       r_addr_p1;
  logic                                r_last_p1;

  logic [1:0]                          r_occ;
  logic                                r_out_val;
  beat_t                               r_head_p2;
  beat_t                               r_skid_p2;

  logic [RESULT_D-1:0]                 w_wr_ok;
  logic [RESULT_D-1:0][RES_WIDTH-1:0]  w_bank_q_p1;
  logic [RES_WIDTH-1:0]                w_rd_word_p1;
  logic                                w_pop;
  logic                                w_done_beat;
  logic [2:0]                          w_fill;
  logic                                w_issue;
  logic                                w_issue_last;
  beat_t                               w_in_p1;

  // Stage p0: read issue. The skid has room for whatever is already in flight.
  assign w_pop        = r_out_val & out_rdy;
  assign w_done_beat  = w_pop & r_head_p2.last;
  assign w_fill       = {1'b0, r_occ} + {2'b00, r_vld_p1} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_DRAIN) && !r_rd_done && (w_fill < 3'd2);
  assign w_issue_last = (r_rd_ch == CW'(RESULT_D-1)) && (r_rd_addr == AW'(N-1));

  for (genvar k = 0; k < RESULT_D; k++) begin : gen_bank
    logic [AW-1:0]        w_wr_addr;
    logic [RES_WIDTH-1:0] w_wr_data;
    logic [RES_WIDTH-1:0] r_mem [N];
    logic [RES_WIDTH-1:0] r_q_p1;

    assign w_wr_addr      = result_wraddress[k*AW +: AW];
    assign w_wr_data      = result_data_out[k*RES_WIDTH +: RES_WIDTH];
    assign w_wr_ok[k]     = result_wren[k] && (int'(w_wr_addr) < N);
    assign w_bank_q_p1[k] = r_q_p1;

    always_ff @(posedge clk) begin
      if ((r_state == S_COLLECT) && w_wr_ok[k])
        r_mem[w_wr_addr] <= w_wr_data;
      if (w_issue)
        r_q_p1 <= r_mem[r_rd_addr];
    end
  end

  // Stage p1: bank outputs registered, channel select feeds the output stage.
  assign w_rd_word_p1 = w_bank_q_p1[r_ch_p1];

  always_comb begin
    w_in_p1      = '0;
    w_in_p1.data = f_relu(w_rd_word_p1);
    w_in_p1.ch   = r_ch_p1;
    w_in_p1.addr = r_addr_p1;
    w_in_p1.last = r_last_p1;
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_ch_p1   <= r_rd_ch;
      r_addr_p1 <= r_rd_addr;
      r_last_p1 <= w_issue_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_COLLECT;
      r_frame_cnt <= '0;
      r_rd_addr   <= '0;
      r_rd_ch     <= '0;
      r_rd_done   <= 1'b0;
      r_err       <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_occ       <= 2'd0;
      r_out_val   <= 1'b0;
      r_head_p2   <= '0;
    end else begin
      r_vld_p1 <= w_issue;

      if (w_issue) begin
        if (r_rd_addr == AW'(N-1)) begin
          r_rd_addr <= '0;
          r_rd_ch   <= r_rd_ch + 1'b1;
        end else begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
        if (w_issue_last)
          r_rd_done <= 1'b1;
      end

      case (r_state)
        S_COLLECT: begin
          if (w_wr_ok[0]) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (r_frame_cnt == CNT_W'(N-1))
              r_state <= S_DRAIN;
          end
        end
        default: begin
          if (|result_wren)
            r_err <= 1'b1;
          if (w_done_beat) begin
            r_state     <= S_COLLECT;
            r_frame_cnt <= '0;
            r_rd_addr   <= '0;
            r_rd_ch     <= '0;
            r_rd_done   <= 1'b0;
          end
        end
      endcase

      // Stage p2: output head register plus one skid entry, kept in order.
      case (r_occ)
        2'd0: begin
          if (r_vld_p1) begin
            r_head_p2 <= w_in_p1;
            r_out_val <= 1'b1;
            r_occ     <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_pop, r_vld_p1})
            2'b11: r_head_p2 <= w_in_p1;
            2'b10: begin
              r_out_val <= 1'b0;
              r_occ     <= 2'd0;
            end
            2'b01: begin
              r_skid_p2 <= w_in_p1;
              r_occ     <= 2'd2;
            end
            default: ;
          endcase
        end
        default: begin
          if (w_pop) begin
            r_head_p2 <= r_skid_p2;
            if (r_vld_p1)
              r_skid_p2 <= w_in_p1;
            else
              r_occ <= 2'd1;
          end
        end
      endcase
    end
  end

  assign out_data    = r_head_p2.data;
  assign out_ch      = r_head_p2.ch;
  assign out_addr    = r_head_p2.addr;
  assign out_last    = r_head_p2.last;
  assign out_val     = r_out_val;
  assign busy        = (r_state == S_DRAIN);
  assign err_overrun = r_err;

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain at default parameters (36 pixels x 8 channels).
module tb_conv_result_drain;

  localparam int N   = 36;
  localparam int D   = 8;
  localparam int TOT = N*D;

  logic          clk;
  logic          reset;
  logic [6*D-1:0]  result_wraddress;
  logic [32*D-1:0] result_data_out;
  logic [D-1:0]  result_wren;
  logic [31:0]   out_data;
  logic [2:0]    out_ch;
  logic [5:0]    out_addr;
  logic          out_last;
  logic          out_val;
  logic          out_rdy;
  logic          busy;
  logic          err_overrun;

  int n_pass;
  int n_total;

  conv_result_drain dut (
    .clk              (clk),
    .reset            (reset),
    .result_wraddress (result_wraddress),
    .result_data_out  (result_data_out),
    .result_wren      (result_wren),
    .out_data         (out_data),
    .out_ch           (out_ch),
    .out_addr         (out_addr),
    .out_last         (out_last),
    .out_val          (out_val),
    .out_rdy          (out_rdy),
    .busy             (busy),
    .err_overrun      (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rdy_mode;
    bit          inject;
    bit          bad_wr;
    bit          special;
    logic [31:0] tag;
    bit          exp_err;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] wr_data(input int ch, input int a, input logic [31:0] tag, input bit special);
    if (special && ch == 0 && a == 0) return 32'hFFFF_FFF0;
    if (special && ch == 0 && a == 1) return 32'h0000_0010;
    return 32'(ch*256 + a) + tag;
  endfunction

  function automatic logic [31:0] exp_data(input int ch, input int a, input logic [31:0] tag, input bit special);
    if (special && ch == 0 && a == 0) begin
`ifdef CONV_RESULT_DRAIN_RELU_EN
      return 32'h0000_0000;
`else
      return 32'hFFFF_FFF0;
`endif
    end
    if (special && ch == 0 && a == 1) return 32'h0000_0010;
    return 32'(ch*256 + a) + tag;
  endfunction

  task automatic write_frame(input logic [31:0] tag, input bit bad, input bit special);
    out_rdy = 1'b0;
    for (int a = 0; a < N; a++) begin
      if (bad && a == 10) begin
        for (int b = 0; b < 2; b++) begin
          result_wren = '1;
          for (int k = 0; k < D; k++) begin
            result_wraddress[k*6 +: 6] = (b == 0) ? 6'd36 : 6'd63;
            result_data_out[k*32 +: 32] = 32'hBAD0_0000;
          end
          step();
        end
      end
      result_wren = '1;
      for (int k = 0; k < D; k++) begin
        result_wraddress[k*6 +: 6] = 6'(a);
        result_data_out[k*32 +: 32] = wr_data(k, a, tag, special);
      end
      step();
      if (a == N-2) chk("busy_before_last_write", 64'(busy), 64'd0);
    end
    result_wren = '0;
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic drain(input int mode, input bit inject, input logic [31:0] tag,
                       input bit special, input int stop_at);
    logic [15:0] lfsr;
    logic [41:0] cur;
    logic [41:0] saved;
    logic [41:0] want;
    bit          was_stall;
    int          i;
    int          cyc;
    int          target;
    lfsr      = 16'hACE1;
    was_stall = 1'b0;
    saved     = '0;
    i         = 0;
    cyc       = 0;
    target    = (stop_at < 0) ? TOT : stop_at;
    out_rdy   = 1'b0;
    chk("lat0_val", 64'(out_val), 64'd0);
    step();
    chk("lat1_val", 64'(out_val), 64'd0);
    step();
    chk("lat2_val", 64'(out_val), 64'd1);
    while (i < target && cyc < 5000) begin
      out_rdy = (mode == 0) ? 1'b1 : lfsr[0];
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      result_wren = '0;
      if (inject && i == 50 && cyc[0]) begin
        result_wren = '1;
        for (int k = 0; k < D; k++) begin
          result_wraddress[k*6 +: 6] = 6'd5;
          result_data_out[k*32 +: 32] = 32'hDEAD_BEEF;
        end
      end
      cur = {out_data, out_ch, out_addr, out_last};
      if (was_stall) begin
        chk("stall_val", 64'(out_val), 64'd1);
        chk("stall_hold", 64'(cur), 64'(saved));
      end
      if (out_val && out_rdy) begin
        want = {exp_data(i / N, i % N, tag, special), 3'(i / N), 6'(i % N), (i == TOT-1)};
        chk($sformatf("beat%0d", i), 64'(cur), 64'(want));
        i++;
      end
      was_stall = out_val && !out_rdy;
      saved     = cur;
      step();
      cyc++;
    end
    result_wren = '0;
    chk("beats_accepted", 64'(i), 64'(target));
    if (stop_at < 0) begin
      if (mode == 0) chk("drain_cycles", 64'(cyc), 64'(TOT));
      chk("busy_fall", 64'(busy), 64'd0);
      chk("val_after_last", 64'(out_val), 64'd0);
      out_rdy = 1'b0;
    end
  endtask

  vec_t tbl [5];

  initial begin
    n_pass           = 0;
    n_total          = 0;
    reset            = 1'b1;
    out_rdy          = 1'b0;
    result_wren      = '0;
    result_wraddress = '0;
    result_data_out  = '0;

    tbl[0] = '{rdy_mode: 0, inject: 1'b0, bad_wr: 1'b0, special: 1'b0, tag: 32'h0000_0000, exp_err: 1'b0};
    tbl[1] = '{rdy_mode: 1, inject: 1'b0, bad_wr: 1'b0, special: 1'b0, tag: 32'h0001_0000, exp_err: 1'b0};
    tbl[2] = '{rdy_mode: 0, inject: 1'b0, bad_wr: 1'b1, special: 1'b0, tag: 32'h0002_0000, exp_err: 1'b0};
    tbl[3] = '{rdy_mode: 0, inject: 1'b0, bad_wr: 1'b0, special: 1'b1, tag: 32'h0003_0000, exp_err: 1'b0};
    tbl[4] = '{rdy_mode: 1, inject: 1'b1, bad_wr: 1'b0, special: 1'b0, tag: 32'h0004_0000, exp_err: 1'b1};

    step();
    step();
    reset = 1'b0;
    chk("rst_val",  64'(out_val), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err",  64'(err_overrun), 64'd0);
    chk("rst_fields", 64'({out_data, out_ch, out_addr}), 64'd0);

    for (int v = 0; v < 5; v++) begin
      write_frame(tbl[v].tag, tbl[v].bad_wr, tbl[v].special);
      drain(tbl[v].rdy_mode, tbl[v].inject, tbl[v].tag, tbl[v].special, -1);
      chk($sformatf("err_overrun_v%0d", v), 64'(err_overrun), 64'(tbl[v].exp_err));
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err_cleared", 64'(err_overrun), 64'd0);

    write_frame(32'h0005_0000, 1'b0, 1'b0);
    drain(0, 1'b0, 32'h0005_0000, 1'b0, 100);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    out_rdy = 1'b0;
    chk("midrst_val",  64'(out_val), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    step();
    chk("midrst_val_hold", 64'(out_val), 64'd0);

    write_frame(32'h0006_0000, 1'b0, 1'b0);
    drain(0, 1'b0, 32'h0006_0000, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_result_drain.md
# conv_result_drain

Result-side collector for the 2-D convolution engines. Accepts the per-output-channel BRAM write ports (`result_wraddress` / `result_data_out` / `result_wren`) driven by the convolution datapath and stores one full result frame in `RESULT_D` internal banks. Once the frame is complete, streams it out channel-major over a valid/ready interface, then re-arms for the next frame.

## Interface
Parameters:
- `DATA_WIDTH`, 8: pixel width; result word width is `RES_WIDTH = DATA_WIDTH*4`
- `RESULT_W`, 6: result frame width
- `RESULT_H`, 6: result frame height
- `RESULT_D`, 8: result channels (= number of filters, one bank each)
- `RESULT_RAM_ADDR_WIDTH`, `$clog2(RESULT_W*RESULT_H)`: derived, not set manually
- `CH_ADDR_WIDTH`, `$clog2(RESULT_D)` (min 1): derived, not set manually

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `result_wraddress`  in  `RESULT_RAM_ADDR_WIDTH*RESULT_D`  per-bank write address; bank k at slice k
- `result_data_out`  in  `RES_WIDTH*RESULT_D`  per-bank write data; bank k at slice k
- `result_wren`  in  `RESULT_D`  per-bank write enable
- `out_data`  out  `RES_WIDTH`  streamed result word
- `out_ch`  out  `CH_ADDR_WIDTH`  channel of `out_data`
- `out_addr`  out  `RESULT_RAM_ADDR_WIDTH`  pixel address (w + h*RESULT_W) of `out_data`
- `out_last`  out  1  final beat of frame
- `out_val`  out  1  output valid
- `out_rdy`  in  1  downstream ready
- `busy`  out  1  high while in DRAIN
- `err_overrun`  out  1  sticky: a write arrived during DRAIN

## Operation
- N = RESULT_W*RESULT_H. States: COLLECT, DRAIN.
- COLLECT: each bank k with `result_wren[k]` and address < N writes its word; addresses ≥ N are dropped. Frame counter increments only on accepted bank-0 writes (all banks are written in lockstep by the engine).
- The write that brings the counter to N moves the FSM to DRAIN on the next edge.
- DRAIN: read pointer (ch, addr) starts at (0,0), advances addr 0..N-1 then ch 0..RESULT_D-1; exactly `RESULT_D*N` beats. `out_last` = 1 only on (RESULT_D-1, N-1).
- Writes in DRAIN are not stored, not counted, and set `err_overrun` (cleared only by reset).
- Beat accepted when `out_val & out_rdy`. On acceptance of the `out_last` beat: FSM → COLLECT, frame counter cleared, read pointer cleared.
- Bank contents are never cleared; each frame overwrites.
- `CONV_RESULT_DRAIN_RELU_EN` transforms `out_data` only (see Configuration).

## Timing
- Reset values: `out_val`=0, `out_last`=0, `busy`=0, `err_overrun`=0, `out_data`/`out_ch`/`out_addr`=0; FSM=COLLECT, counters 0.
- Bank read latency 1 cycle, registered output stage: first `out_val` 2 cycles after `busy` rises.
- With `out_rdy` held high: one beat per cycle, no bubbles; a frame drains in `RESULT_D*N` consecutive cycles.
- Valid/ready: once `out_val`=1, `out_data`/`out_ch`/`out_addr`/`out_last` are held stable until accepted; `out_val` never drops without acceptance. Stall by deasserting `out_rdy` at any cycle loses and duplicates no beat (2-entry skid absorbs the in-flight read).
- `out_rdy` has no combinational path to `out_val` (`out_val` is a register).
- `busy` falls the cycle after the last beat is accepted; a write in that cycle (COLLECT) is accepted.
- Reset mid-DRAIN: next cycle COLLECT, `out_val`=0, skid flushed, counters 0.

## Configuration
- `CONV_RESULT_DRAIN_RELU_EN` defined: `out_data` = 0 when the stored word is negative (MSB = 1, two's complement), else the stored word; applied in the output register stage, latency unchanged.
- Undefined: `out_data` is the stored word unmodified.

## Test plan
- Defaults (N=36, D=8): write bank k addr a with data k*256+a for all banks, 36 cycles; `out_rdy`=1 → `busy` rises after write 36, 288 beats in order, beat i has ch=i/36, addr=i%36, data=ch*256+addr, `out_last` only on beat 287, `busy` low one cycle later.
- Same frame, `out_rdy` toggled with pseudo-random pattern (~50%) → identical 288-beat sequence, fields stable during every stall.
- During DRAIN assert `result_wren`=8'hFF → `err_overrun`=1 and stays 1, drained data unchanged; after reset `err_overrun`=0.
- Writes at address 36 and 63 in COLLECT → ignored, counter unchanged; 36 valid writes still trigger DRAIN.
- Reset asserted at beat 100 with `out_rdy`=1 → `out_val`=0 next cycle; new 36-write frame drains from (0,0).
- With `CONV_RESULT_DRAIN_RELU_EN`: stored 32'hFFFF_FFF0 → `out_data`=0; stored 32'h0000_0010 → 32'h0000_0010; without macro first word reads 32'hFFFF_FFF0.
